// File: rtl/mem_copy_if.sv
// Handshake bundle between the copy controller (master) and its
// requester/memory environment (slave).
interface mem_copy_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start_i;
    logic [ADDR_W-1:0] src_addr_i;
    logic [ADDR_W-1:0] dst_addr_i;
    logic [LEN_W-1:0]  len_i;
    logic              read_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_valid_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              write_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_ready_i;
    logic              done_o;
    logic              busy_o;

    modport master (
        input  start_i, src_addr_i, dst_addr_i, len_i, rd_valid_i, rd_data_i, wr_ready_i,
        output read_o, rd_addr_o, write_o, wr_addr_o, wr_data_o, done_o, busy_o
    );

    modport slave (
        output start_i, src_addr_i, dst_addr_i, len_i, rd_valid_i, rd_data_i, wr_ready_i,
        input  read_o, rd_addr_o, write_o, wr_addr_o, wr_data_o, done_o, busy_o
    );
endinterface

// File: rtl/mem_copy_ctrl.sv
// Word-at-a-time memory copy engine: read one word, buffer it, write it,
// repeat until the captured length is exhausted, then pulse done.
module mem_copy_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_copy_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              read_q, write_q, done_q, busy_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    src_d   = bus.src_addr_i;
                    dst_d   = bus.dst_addr_i;
                    cnt_d   = bus.len_i;
                    state_d = (bus.len_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.rd_valid_i) begin
                    buf_d   = bus.rd_data_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.wr_ready_i) begin
                    // Pointers wrap silently at 2^ADDR_W.
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave flops cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            read_q  <= (state_d == S_READ);
            write_q <= (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.read_o    = read_q;
    assign bus.rd_addr_o = src_q;
    assign bus.write_o   = write_q;
    assign bus.wr_addr_o = dst_q;
    assign bus.wr_data_o = buf_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Scoreboard bench for mem_copy_ctrl: a memory responder answers reads,
// a monitor pops expected reads/writes whenever the DUT strobes.
module tb_mem_copy_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_copy_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();
    mem_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int total = 0;
    int bad = 0;
    logic [AW-1:0] rd_exp[$];
    wr_t           wr_exp[$];
    int done_exp = 0;
    int done_seen = 0;
    int stalls_seen = 0;
    int rd_lat = 1;
    int stall_n = 0;
    bit spur_en = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_read"},    bus.read_o,    1'b0);
        chk({tag, "_write"},   bus.write_o,   1'b0);
        chk({tag, "_done"},    bus.done_o,    1'b0);
        chk({tag, "_busy"},    bus.busy_o,    1'b0);
        chk({tag, "_rd_addr"}, bus.rd_addr_o, '0);
        chk({tag, "_wr_addr"}, bus.wr_addr_o, '0);
        chk({tag, "_wr_data"}, bus.wr_data_o, '0);
    endtask

    task automatic push_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(s + AW'(i));
            wr_exp.push_back('{addr: d + AW'(i), data: mem_word(s + AW'(i))});
        end
        done_exp++;
    endtask

    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        @(negedge clk);
        bus.start_i = 1'b1; bus.src_addr_i = s; bus.dst_addr_i = d; bus.len_i = n;
        push_xfer(s, d, int'(n));
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done expected done", tag);
        end
        @(negedge clk);
    endtask

    // Memory side: returns read data rd_lat cycles after read_o, can stall
    // writes for stall_n cycles, and can inject rd_valid while writing.
    initial begin : responder
        int cd = 0;
        int st = 0;
        logic [AW-1:0] a = '0;
        bus.rd_valid_i = 1'b0; bus.rd_data_i = '0; bus.wr_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            bus.rd_valid_i = 1'b0;
            if (!rst_n) begin cd = 0; st = 0; end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin bus.rd_valid_i = 1'b1; bus.rd_data_i = mem_word(a); end
            end
            if (bus.read_o) begin cd = rd_lat; a = bus.rd_addr_o; end
            if (bus.write_o && spur_en) begin bus.rd_valid_i = 1'b1; bus.rd_data_i = 32'hDEAD_BEEF; end
            if (bus.write_o && st < stall_n) begin
                bus.wr_ready_i = 1'b0; st++;
            end else begin
                bus.wr_ready_i = 1'b1;
                if (bus.write_o) st = 0;
            end
        end
    end

    initial begin : monitor
        bit have = 1'b0;
        bit prev_done = 1'b0;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                have = 1'b0; prev_done = 1'b0;
            end else begin
                total++;
                if (bus.read_o && bus.write_o) begin
                    bad++;
                    $display("FAIL rd_wr_overlap: got read=1 write=1 expected not both");
                end
                if (prev_done) chk("busy_after_done", bus.busy_o, 1'b0);
                prev_done = bus.done_o;
                if (bus.read_o) begin
                    if (rd_exp.size() == 0) fail("unexpected_read");
                    else chk("rd_addr", bus.rd_addr_o, rd_exp.pop_front());
                end
                if (bus.write_o) begin
                    if (have) begin
                        chk("stall_wr_addr", bus.wr_addr_o, sa);
                        chk("stall_wr_data", bus.wr_data_o, sd);
                    end
                    if (!bus.wr_ready_i) begin
                        have = 1'b1; sa = bus.wr_addr_o; sd = bus.wr_data_o; stalls_seen++;
                    end else begin
                        have = 1'b0;
                        if (wr_exp.size() == 0) fail("unexpected_write");
                        else begin
                            e = wr_exp.pop_front();
                            chk("wr_addr", bus.wr_addr_o, e.addr);
                            chk("wr_data", bus.wr_data_o, e.data);
                        end
                    end
                end
                if (bus.done_o) done_seen++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nw;
        bus.start_i = 1'b0; bus.src_addr_i = '0; bus.dst_addr_i = '0; bus.len_i = '0;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic three-word copy.
        issue(32'h0000_0100, 32'h0000_0200, 16'd3);
        wait_done("basic");

        // Zero length: done the cycle after start, no memory traffic.
        @(negedge clk);
        bus.start_i = 1'b1; bus.len_i = '0; done_exp++;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("len0_done", bus.done_o, 1'b1);
        chk("len0_busy", bus.busy_o, 1'b1);
        @(negedge clk);
        chk("len0_idle_done", bus.done_o, 1'b0);
        chk("len0_idle_busy", bus.busy_o, 1'b0);

        // Write back-pressure for five cycles.
        stall_n = 5;
        issue(32'h0000_0300, 32'h0000_0400, 16'd1);
        wait_done("stall");
        stall_n = 0;
        chk("stall_cycles", stalls_seen, 5);

        // Source pointer wraps to zero.
        issue(32'hFFFF_FFFF, 32'h0000_0500, 16'd2);
        wait_done("wrap");

        // Start pulsed while waiting on read data; spurious rd_valid in WRITE.
        rd_lat = 3; spur_en = 1'b1;
        issue(32'h0000_0600, 32'h0000_0700, 16'd2);
        @(negedge clk);
        bus.start_i = 1'b1; bus.src_addr_i = 32'h999; bus.dst_addr_i = 32'h999; bus.len_i = 16'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("busy_start");
        rd_lat = 1; spur_en = 1'b0;

        // Start held high through DONE launches a second transfer.
        @(negedge clk);
        bus.start_i = 1'b1; bus.src_addr_i = 32'h800; bus.dst_addr_i = 32'h900; bus.len_i = 16'd1;
        push_xfer(32'h800, 32'h900, 1);
        push_xfer(32'h800, 32'h900, 1);
        wait_done("held_first");
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("held_restart_busy", bus.busy_o, 1'b1);
        wait_done("held_second");

        // Reset during the second write of a four-word transfer.
        @(negedge clk);
        bus.start_i = 1'b1; bus.src_addr_i = 32'hA00; bus.dst_addr_i = 32'hB00; bus.len_i = 16'd4;
        rd_exp.push_back(32'hA00);
        rd_exp.push_back(32'hA01);
        wr_exp.push_back('{addr: 32'hB00, data: mem_word(32'hA00)});
        @(negedge clk);
        bus.start_i = 1'b0;
        nw = 0;
        for (int i = 0; i < 100 && nw < 2; i++) begin
            @(negedge clk);
            if (bus.write_o) nw++;
        end
        chk("abort_reached_write2", nw, 2);
        rst_n = 1'b0;
        #1 chk_zero("abort");
        chk("abort_rd_queue", rd_exp.size(), 0);
        chk("abort_wr_queue", wr_exp.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0C00, 32'h0000_0D00, 16'd1);
        wait_done("after_abort");

        repeat (3) @(negedge clk);
        chk("done_count", done_seen, done_exp);
        chk("rd_left", rd_exp.size(), 0);
        chk("wr_left", wr_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
